// File: rtl/exe_muldiv.sv
// EX-stage multi-cycle multiply/divide unit producing a HI/LO pair for EX/MEM.
// Optional MULDIV_EARLY_OUT_EN: divides with |dividend| < |divisor| finish in one cycle.
module exe_muldiv #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              exe_stall_i,
   input  logic              start_i,
   input  logic [1:0]        op_i,
   input  logic [DATA_W-1:0] opa_i,
   input  logic [DATA_W-1:0] opb_i,
   output logic              stall_req_o,
   output logic              done_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0]        cnt_q;
   logic                    sgn_q, neg_q_q, neg_r_q;
   logic [DATA_W-1:0]       a_q, b_q, rem_q, quo_q, hi_q, lo_q;

   logic                    op_signed, is_div, div_zero, early;
   logic [DATA_W-1:0]       a_mag, b_mag;
   logic [DATA_W:0]         rem_shift, diff;
   logic [DATA_W-1:0]       rem_step, quo_step;
   logic signed [2*DATA_W-1:0] ext_a, ext_b, prod;
   logic                    last_iter;

   function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x, input logic neg);
      return neg ? (~x + DATA_W'(1)) : x;
   endfunction

   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] x, input logic sgn);
      return negate(x, sgn & x[DATA_W-1]);
   endfunction

   assign op_signed = ~op_i[0];
   assign is_div    = op_i[1];
   assign a_mag     = magnitude(opa_i, op_signed);
   assign b_mag     = magnitude(opb_i, op_signed);
   assign div_zero  = (opb_i == '0);
`ifdef MULDIV_EARLY_OUT_EN
   assign early     = is_div & ~div_zero & (a_mag < b_mag);
`else
   assign early     = 1'b0;
`endif

   // Restoring step: shift in the next dividend bit and try subtracting the divisor.
   assign rem_shift = {rem_q, quo_q[DATA_W-1]};
   assign diff      = rem_shift - {1'b0, b_q};
   assign rem_step  = diff[DATA_W] ? rem_shift[DATA_W-1:0] : diff[DATA_W-1:0];
   assign quo_step  = {quo_q[DATA_W-2:0], ~diff[DATA_W]};
   assign last_iter = (cnt_q == CNT_W'(DATA_W - 1));

   // Sign-extend only for MULT so the truncated 2W-bit product is right for both ops.
   assign ext_a = $signed({{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q});
   assign ext_b = $signed({{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q});
   assign prod  = ext_a * ext_b;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start_i) begin
            if (!is_div)                state_nxt = MUL;
            else if (div_zero || early) state_nxt = DONE;
            else                        state_nxt = DIV;
         end
         MUL:  state_nxt = DONE;
         DIV:  if (last_iter) state_nxt = DONE;
         DONE: if (!exe_stall_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush_i) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         sgn_q   <= 1'b0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else if (!flush_i) begin
         case (state)
            IDLE: if (start_i) begin
               sgn_q   <= op_signed;
               a_q     <= opa_i;
               b_q     <= is_div ? b_mag : opb_i;
               quo_q   <= a_mag;
               rem_q   <= '0;
               cnt_q   <= '0;
               neg_q_q <= op_signed & (opa_i[DATA_W-1] ^ opb_i[DATA_W-1]);
               neg_r_q <= op_signed & opa_i[DATA_W-1];
               if (is_div && (div_zero || early)) begin
                  hi_q <= opa_i;
                  lo_q <= div_zero ? '1 : '0;
               end
            end
            MUL: {hi_q, lo_q} <= prod;
            DIV: begin
               rem_q <= rem_step;
               quo_q <= quo_step;
               cnt_q <= cnt_q + CNT_W'(1);
               if (last_iter) begin
                  lo_q <= negate(quo_step, neg_q_q);
                  hi_q <= negate(rem_step, neg_r_q);
               end
            end
            default: ;
         endcase
      end
   end

   assign stall_req_o = ~flush_i & (((state == IDLE) & start_i) | (state == MUL) | (state == DIV));
   assign done_o      = ~flush_i & (state == DONE);
   assign hi_o        = hi_q;
   assign lo_o        = lo_q;

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: mul/div results, latency, stall, flush, hold and reset.
module tb_exe_muldiv;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i, exe_stall_i, start_i;
   logic [1:0]  op_i;
   logic [31:0] opa_i, opb_i;
   logic        stall_req_o, done_o;
   logic [31:0] hi_o, lo_o;

   int checks = 0;
   int errors = 0;

   localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

   exe_muldiv #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .exe_stall_i(exe_stall_i),
      .start_i(start_i), .op_i(op_i), .opa_i(opa_i), .opb_i(opb_i),
      .stall_req_o(stall_req_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one op, count latency and stall cycles, check result and that done drops after.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int lat, st;
      @(negedge clk);
      op_i = op; opa_i = a; opb_i = b; start_i = 1'b1;
      #1;
      lat = 0; st = 0;
      while (!done_o && lat < 100) begin
         if (stall_req_o) st++;
         @(negedge clk);
         start_i = 1'b0; opa_i = ~a; opb_i = b + 32'd1;
         #1;
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_stall"}, 64'(st), 64'(exp_lat));
      chk({tag, "_hi"}, hi_o, exp_hi);
      chk({tag, "_lo"}, lo_o, exp_lo);
      chk({tag, "_stall_in_done"}, stall_req_o, 1'b0);
      @(negedge clk);
      #1;
      chk({tag, "_done_drop"}, done_o, 1'b0);
   endtask

   initial begin
      int lat, cnt, early_lat;
      rst = 1'b1; flush_i = 1'b0; exe_stall_i = 1'b0; start_i = 1'b0;
      op_i = 2'b00; opa_i = '0; opb_i = '0;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_hi", hi_o, 32'h0);
      chk("rst_lo", lo_o, 32'h0);
      chk("rst_done", done_o, 1'b0);
      chk("rst_stall", stall_req_o, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      run_op("mult_neg", OP_MULT, 32'hFFFFFFFE, 32'h00000003, 2, 32'hFFFFFFFF, 32'hFFFFFFFA);
      run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 32'hFFFFFFFE, 32'h00000001);
      run_op("mult_mix", OP_MULT, 32'h80000000, 32'h80000000, 2, 32'h40000000, 32'h00000000);
      run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div_7_m2", OP_DIV, 32'h00000007, 32'hFFFFFFFE, 33, 32'h00000001, 32'hFFFFFFFD);
      run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
      run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000, 32'h80000000);
      run_op("divu_big", OP_DIVU, 32'hFFFFFFF9, 32'h00000002, 33, 32'h00000001, 32'h7FFFFFFC);
      run_op("divu_zero", OP_DIVU, 32'h12345678, 32'h0, 1, 32'h12345678, 32'hFFFFFFFF);
      run_op("div_zero", OP_DIV, 32'hFFFFFFFB, 32'h0, 1, 32'hFFFFFFFB, 32'hFFFFFFFF);

`ifdef MULDIV_EARLY_OUT_EN
      early_lat = 1;
`else
      early_lat = 33;
`endif
      run_op("divu_3_5", OP_DIVU, 32'd3, 32'd5, early_lat, 32'd3, 32'd0);
      run_op("div_m3_5", OP_DIV, 32'hFFFFFFFD, 32'd5, early_lat, 32'hFFFFFFFD, 32'd0);

      // Flush at divide iteration 10; prior result is hi=0xFFFFFFFD, lo=0.
      @(negedge clk);
      op_i = OP_DIV; opa_i = 32'd1000; opb_i = 32'd3; start_i = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         start_i = 1'b0;
      end
      #1;
      chk("flush_pre_stall", stall_req_o, 1'b1);
      flush_i = 1'b1;
      #1;
      chk("flush_stall", stall_req_o, 1'b0);
      chk("flush_done", done_o, 1'b0);
      @(negedge clk);
      flush_i = 1'b0;
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (done_o || stall_req_o) cnt++;
         @(negedge clk);
      end
      chk("flush_no_done", 64'(cnt), 64'd0);
      chk("flush_hi_kept", hi_o, 32'hFFFFFFFD);
      chk("flush_lo_kept", lo_o, 32'd0);
      run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 33, 32'd0, 32'd3);

      // DONE held by exe_stall_i for 3 cycles.
      @(negedge clk);
      op_i = OP_DIVU; opa_i = 32'd5; opb_i = 32'd3; start_i = 1'b1;
      #1;
      lat = 0;
      while (!done_o && lat < 100) begin
         @(negedge clk);
         start_i = 1'b0;
         #1;
         lat++;
      end
      chk("hold_lat", 64'(lat), 64'd33);
      exe_stall_i = 1'b1;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (done_o) cnt++;
         @(negedge clk);
         if (i == 2) exe_stall_i = 1'b0;
      end
      chk("hold_done_cycles", 64'(cnt), 64'd4);
      chk("hold_hi", hi_o, 32'd2);
      chk("hold_lo", lo_o, 32'd1);
      #1;
      chk("hold_no_restart", stall_req_o, 1'b0);

      // Asynchronous reset in the middle of a divide.
      @(negedge clk);
      op_i = OP_DIVU; opa_i = 32'd77; opb_i = 32'd5; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("arst_hi", hi_o, 32'h0);
      chk("arst_lo", lo_o, 32'h0);
      chk("arst_stall", stall_req_o, 1'b0);
      chk("arst_done", done_o, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("arst_idle_done", done_o, 1'b0);
      run_op("post_rst_mult", OP_MULT, 32'd7, 32'hFFFFFFFF, 2, 32'hFFFFFFFF, 32'hFFFFFFF9);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
